// File: rtl/calc_sequencer.sv
// Instruction sequencer for the calculator: a 16-word program memory loaded over
// valid/ready, issued one word per clock, then a readback of the final destination.
module calc_sequencer #(
    parameter int unsigned PC_W    = 4,
    parameter int unsigned INSTR_W = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [PC_W-1:0]    load_addr,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [3:0]         result,
    output logic [1:0]         rd_addr,
    output logic [3:0]         immediate,
    output logic [1:0]         we_addr,
    output logic [2:0]         control,
    input  logic [3:0]         rd_data
);

    localparam int unsigned DEPTH = 1 << PC_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        READBACK = 2'd2
    } state_t;

    state_t             state;
    logic [INSTR_W-1:0] mem [DEPTH];
    // Extra MSB marks "word 15 already issued" so the run never wraps to pc 0.
    logic [PC_W:0]      pc;
    logic               last_q;
    logic [1:0]         dst_q;
    logic [INSTR_W-1:0] fetch_word;

    assign fetch_word = mem[pc[PC_W-1:0]];

    // Program memory: writable only while idle, deliberately not reset.
    always_ff @(posedge clk) begin
        if (!reset && state == IDLE && load_valid) begin
            mem[load_addr] <= load_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= '0;
            last_q     <= 1'b0;
            dst_q      <= 2'd0;
            rd_addr    <= 2'd0;
            immediate  <= 4'hF;
            we_addr    <= 2'd0;
            control    <= 3'b000;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 4'd0;
            load_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // pc is 0 here, so fetch_word is mem[0]; a load wins over start.
                    if (!load_valid && start) begin
                        rd_addr    <= fetch_word[10:9];
                        immediate  <= fetch_word[8:5];
                        we_addr    <= fetch_word[4:3];
                        control    <= fetch_word[2:0];
                        last_q     <= fetch_word[11];
                        dst_q      <= fetch_word[4:3];
                        pc         <= (PC_W + 1)'(1);
                        busy       <= 1'b1;
                        load_ready <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (last_q || pc[PC_W]) begin
                        rd_addr   <= dst_q;
                        immediate <= 4'hF;
                        we_addr   <= dst_q;
                        control   <= 3'b000;
                        state     <= READBACK;
                    end else begin
                        rd_addr   <= fetch_word[10:9];
                        immediate <= fetch_word[8:5];
                        we_addr   <= fetch_word[4:3];
                        control   <= fetch_word[2:0];
                        last_q    <= fetch_word[11];
                        dst_q     <= fetch_word[4:3];
                        pc        <= pc + (PC_W + 1)'(1);
                    end
                end
                READBACK: begin
                    result     <= rd_data;
                    done       <= 1'b1;
                    rd_addr    <= 2'd0;
                    immediate  <= 4'hF;
                    we_addr    <= 2'd0;
                    control    <= 3'b000;
                    pc         <= '0;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: behavioural calculator on the instruction port and a
// queue of expected readback values popped when done fires.
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [3:0]  load_addr;
    logic [11:0] load_instr;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  result;
    logic [1:0]  rd_addr;
    logic [3:0]  immediate;
    logic [1:0]  we_addr;
    logic [2:0]  control;
    logic [3:0]  rd_data;

    int          asserts = 0;
    int          failures = 0;
    logic [3:0]  exp_q[$];
    logic        calc_en = 1'b0;
    logic [3:0]  regs [4];

    always #5 clk = ~clk;

    calc_sequencer #(.PC_W(4), .INSTR_W(12)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_instr(load_instr),
        .start(start), .busy(busy), .done(done), .result(result),
        .rd_addr(rd_addr), .immediate(immediate), .we_addr(we_addr),
        .control(control), .rd_data(rd_data)
    );

    function automatic logic [3:0] alu(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] ctl);
        case (ctl)
            3'b000, 3'b011: return a & b;
            3'b001:         return a | b;
            3'b010:         return a + b;
            3'b100:         return a & ~b;
            3'b101:         return a | ~b;
            3'b110:         return a - b;
            default:        return {3'b000, ($signed(a) < $signed(b))};
        endcase
    endfunction

    // Calculator model: commits on every falling edge, reads rd_addr combinationally.
    always @(negedge clk) begin
        if (!calc_en) begin
            for (int i = 0; i < 4; i++) regs[i] <= 4'd0;
        end else begin
            regs[we_addr] <= alu(regs[rd_addr], immediate, control);
        end
    end
    assign rd_data = regs[rd_addr];

    function automatic logic [11:0] mk(input logic last, input logic [1:0] rd,
                                       input logic [3:0] imm, input logic [1:0] we,
                                       input logic [2:0] ctl);
        return {last, rd, imm, we, ctl};
    endfunction

    task automatic load_word(input logic [3:0] addr, input logic [11:0] instr);
        @(negedge clk);
        load_valid = 1'b1;
        load_addr  = addr;
        load_instr = instr;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Pulses start and observes the run; all judgement stays with the caller.
    task automatic run_start(output int lat, output int busy_cnt, output logic [3:0] res,
                             output bit seen, output logic [10:0] first_issue,
                             output logic done_after);
        lat = 0; busy_cnt = 0; res = 4'd0; seen = 1'b0; done_after = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        first_issue = {rd_addr, immediate, we_addr, control};
        if (busy) busy_cnt++;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) begin
                seen = 1'b1;
                res  = result;
            end else if (busy) begin
                busy_cnt++;
            end
        end
        @(posedge clk);
        #1;
        done_after = done;
    endtask

    task automatic test_reset;
        reset = 1'b1; load_valid = 1'b0; load_addr = 4'd0; load_instr = 12'd0; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        calc_en = 1'b1;
        asserts++;
        if ({rd_addr, immediate, we_addr, control} !== {2'd0, 4'hF, 2'd0, 3'd0}) begin
            failures++;
            $display("FAIL reset_nop: got %h required %h",
                     {rd_addr, immediate, we_addr, control}, {2'd0, 4'hF, 2'd0, 3'd0});
        end
        asserts++;
        if ({busy, done, result, load_ready} !== {1'b0, 1'b0, 4'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_status: busy/done/result/ready got %b required %b",
                     {busy, done, result, load_ready}, {1'b0, 1'b0, 4'd0, 1'b1});
        end
    endtask

    task automatic test_two_instr;
        int lat, bc; logic [3:0] res; bit seen; logic [10:0] fi; logic da;
        load_word(4'd0, mk(1'b0, 2'd0, 4'd5, 2'd1, 3'b010));
        load_word(4'd1, mk(1'b1, 2'd1, 4'd3, 2'd2, 3'b110));
        exp_q.push_back(4'd2);
        run_start(lat, bc, res, seen, fi, da);
        asserts++;
        if (fi !== {2'd0, 4'd5, 2'd1, 3'b010}) begin
            failures++; $display("FAIL two_first_issue: got %h required %h", fi, {2'd0, 4'd5, 2'd1, 3'b010});
        end
        asserts++;
        if (!seen) begin
            failures++; $display("FAIL two_timeout: done not seen within 40 cycles");
            void'(exp_q.pop_front());
        end else if (res !== exp_q[0]) begin
            failures++; $display("FAIL two_result: got %0d required %0d", res, exp_q.pop_front());
        end else void'(exp_q.pop_front());
        asserts++;
        if (lat != 3) begin failures++; $display("FAIL two_latency: got %0d required 3", lat); end
        asserts++;
        if (bc != 3) begin failures++; $display("FAIL two_busy_cycles: got %0d required 3", bc); end
        asserts++;
        if (da !== 1'b0) begin failures++; $display("FAIL two_done_pulse: done still %b a cycle later", da); end
    endtask

    task automatic test_single;
        int lat, bc; logic [3:0] res; bit seen; logic [10:0] fi; logic da;
        load_word(4'd0, mk(1'b1, 2'd1, 4'd7, 2'd1, 3'b111));
        exp_q.push_back(4'd1);
        run_start(lat, bc, res, seen, fi, da);
        asserts++;
        if (!seen) begin
            failures++; $display("FAIL single_timeout: done not seen");
            void'(exp_q.pop_front());
        end else if (res !== exp_q[0]) begin
            failures++; $display("FAIL single_result: got %0d required %0d", res, exp_q.pop_front());
        end else void'(exp_q.pop_front());
        asserts++;
        if (lat != 2) begin failures++; $display("FAIL single_latency: got %0d required 2", lat); end
    endtask

    task automatic test_load_start_collide;
        int lat, bc; logic [3:0] res; bit seen; logic [10:0] fi; logic da;
        int busy_seen;
        @(negedge clk);
        load_valid = 1'b1; start = 1'b1;
        load_addr = 4'd0; load_instr = mk(1'b1, 2'd0, 4'd9, 2'd3, 3'b010);
        @(negedge clk);
        load_valid = 1'b0; start = 1'b0;
        busy_seen = 0;
        repeat (3) begin
            if (busy) busy_seen++;
            @(negedge clk);
        end
        asserts++;
        if (busy_seen != 0) begin failures++; $display("FAIL collide_no_run: busy seen %0d cycles required 0", busy_seen); end
        exp_q.push_back(4'd9);
        run_start(lat, bc, res, seen, fi, da);
        asserts++;
        if (!seen) begin
            failures++; $display("FAIL collide_timeout: done not seen");
            void'(exp_q.pop_front());
        end else if (res !== exp_q[0]) begin
            failures++; $display("FAIL collide_result: got %0d required %0d", res, exp_q.pop_front());
        end else void'(exp_q.pop_front());
    endtask

    task automatic test_no_last;
        int lat, bc; logic [3:0] res; bit seen; logic [10:0] fi; logic da;
        for (int i = 0; i < 16; i++) begin
            load_word(4'(i), mk(1'b0, 2'(i % 4), 4'hF, 2'(i % 4), 3'b000));
        end
        exp_q.push_back(4'd9);
        run_start(lat, bc, res, seen, fi, da);
        asserts++;
        if (!seen) begin
            failures++; $display("FAIL nolast_timeout: done not seen");
            void'(exp_q.pop_front());
        end else if (res !== exp_q[0]) begin
            failures++; $display("FAIL nolast_result: got %0d required %0d", res, exp_q.pop_front());
        end else void'(exp_q.pop_front());
        asserts++;
        if (lat != 17) begin failures++; $display("FAIL nolast_latency: got %0d required 17", lat); end
        asserts++;
        if (bc != 17) begin failures++; $display("FAIL nolast_busy_cycles: got %0d required 17", bc); end
    endtask

    task automatic test_load_during_run;
        int lat, bc; logic [3:0] res; bit seen; logic [10:0] fi; logic da;
        load_word(4'd0, mk(1'b0, 2'd0, 4'd1, 2'd1, 3'b010));
        load_word(4'd1, mk(1'b1, 2'd1, 4'd1, 2'd1, 3'b010));
        exp_q.push_back(4'd2);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        load_valid = 1'b1; load_addr = 4'd1; load_instr = mk(1'b1, 2'd0, 4'd7, 2'd1, 3'b010);
        asserts++;
        if (load_ready !== 1'b0) begin failures++; $display("FAIL run_load_ready: got %b required 0", load_ready); end
        seen = 1'b0; res = 4'd0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            load_valid = 1'b0;
            if (done) begin seen = 1'b1; res = result; end
        end
        asserts++;
        if (!seen) begin
            failures++; $display("FAIL runload_timeout: done not seen");
            void'(exp_q.pop_front());
        end else if (res !== exp_q[0]) begin
            failures++; $display("FAIL runload_result: got %0d required %0d", res, exp_q.pop_front());
        end else void'(exp_q.pop_front());
        exp_q.push_back(4'd2);
        run_start(lat, bc, res, seen, fi, da);
        asserts++;
        if (!seen) begin
            failures++; $display("FAIL mem_unchanged_timeout: done not seen");
            void'(exp_q.pop_front());
        end else if (res !== exp_q[0]) begin
            failures++; $display("FAIL mem_unchanged_result: got %0d required %0d", res, exp_q.pop_front());
        end else void'(exp_q.pop_front());
    endtask

    task automatic test_reset_mid_run;
        int done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        asserts++;
        if ({rd_addr, immediate, we_addr, control} !== {2'd0, 4'hF, 2'd0, 3'd0}) begin
            failures++;
            $display("FAIL midrst_nop: got %h required %h",
                     {rd_addr, immediate, we_addr, control}, {2'd0, 4'hF, 2'd0, 3'd0});
        end
        asserts++;
        if ({busy, done, result, load_ready} !== {1'b0, 1'b0, 4'd0, 1'b1}) begin
            failures++;
            $display("FAIL midrst_status: busy/done/result/ready got %b required %b",
                     {busy, done, result, load_ready}, {1'b0, 1'b0, 4'd0, 1'b1});
        end
        done_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done !== 1'b0) done_cnt++;
        end
        asserts++;
        if (done_cnt != 0) begin failures++; $display("FAIL midrst_no_done: done seen %0d times required 0", done_cnt); end
        asserts++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_empty: %0d left required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_two_instr();
        test_single();
        test_load_start_collide();
        test_no_last();
        test_load_during_run();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Program sequencer that drives the instruction side of `calculator`. It holds a 16-entry instruction memory loaded over a valid/ready port. On `start` it issues one instruction per clock on the calculator's `rd_addr`/`immediate`/`we_addr`/`control` inputs. After the last instruction it reads back the destination register and reports it on `result` with a one-cycle `done` pulse.

## Interface
- `PC_W`, 4: program counter width; memory depth is 2^PC_W = 16.
- `INSTR_W`, 12: instruction width. Fixed: bit 11 `last`, [10:9] `rd_addr`, [8:5] `immediate`, [4:3] `we_addr`, [2:0] `control`.

Ports:
- `clk`  in  1  clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high.
- `load_valid`  in  1  load request.
- `load_ready`  out  1  high only in IDLE.
- `load_addr`  in  PC_W  memory word to write.
- `load_instr`  in  INSTR_W  instruction word.
- `start`  in  1  begin execution at pc 0; sampled in IDLE only.
- `busy`  out  1  high in RUN and READBACK.
- `done`  out  1  one-cycle pulse when `result` is updated.
- `result`  out  4  readback of the last destination register; held until the next `done`.
- `rd_addr`  out  2  to `calculator`.
- `immediate`  out  4  to `calculator`.
- `we_addr`  out  2  to `calculator`.
- `control`  out  3  to `calculator`. Opcodes: 000 AND, 001 OR, 010 ADD, 011 AND, 100 a&~b, 101 a|~b, 110 SUB, 111 SLT.
- `rd_data`  in  4  from `calculator`.

## Operation
- NOP definition:
  - The calculator writes `we_addr` on every falling edge, so the outputs must never be idle-undefined.
  - NOP(r) = `rd_addr`=r, `we_addr`=r, `immediate`=4'hF, `control`=000. This computes r & F = r, so the register is unchanged.
- Reset values:
  - State IDLE, pc 0.
  - Outputs NOP(0): `rd_addr` 0, `immediate` F, `we_addr` 0, `control` 000.
  - `busy` 0, `done` 0, `result` 0.
  - Instruction memory is NOT cleared.
- States:
  - IDLE:
    - Drives NOP(0).
    - If `load_valid`, write mem[`load_addr`] = `load_instr` at the edge; `start` is ignored in that cycle.
    - Else if `start`: load outputs from mem[0], set pc=1, latch `last_q`=mem[0].last and `dst_q`=mem[0].we_addr, go to RUN.
  - RUN:
    - If `last_q` is set, or the issued pc was 15: go to READBACK and drive NOP(`dst_q`).
    - Else: drive mem[pc], update `last_q`/`dst_q`, pc++.
  - READBACK:
    - Capture `result` = `rd_data` at the edge.
    - Assert `done` for the next cycle, drive NOP(0), go to IDLE.
- Load/start interaction:
  - `load_valid` in RUN/READBACK is not accepted; `load_ready`=0 and memory is unchanged.
  - `start` outside IDLE is ignored.
- Boundaries:
  - Program without a `last` flag executes exactly 16 instructions; pc never wraps to 0 during a run.
  - A loaded word takes effect for any `start` sampled on a later edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Let E0 be the edge that samples `start`, and N the instruction count (1..16).
- Instruction k is presented from E0+k until E0+k+1. The calculator commits it on the falling edge inside that window.
- NOP(dst) is presented from E0+N. `rd_data` at E0+N+1 reflects the committed final value.
- `result` updates and `done`=1 during the cycle after E0+N+1; `busy`=1 from E0 to E0+N+1 exclusive.
- Start-to-done latency: N+1 cycles. Next `start` is accepted at E0+N+2 at the earliest.
- Reset mid-run:
  - At the reset edge: IDLE, NOP(0), `busy`=0, `done`=0.
  - `result` is cleared to 0.
  - The calculator's register contents are unaffected.

## Test plan
- Load mem[0] = {0,00,0101,01,010} (r1 = r0 + 5) and mem[1] = {1,01,0011,10,110} (r2 = r1 − 3). Start with registers at 0 -> `done` at E0+3, `result` = 2, `busy` high for 3 cycles.
- Load a single instruction {1,01,0111,01,111} (r1 = SLT(r1,7)) after the previous test -> `result` = 0001, N=1 latency 2 cycles.
- `load_valid` and `start` asserted together in IDLE -> word written, no run, `busy` stays 0. A `start` on the next cycle runs the new word.
- 16 words with `last`=0, all NOP-equivalent -> exactly 16 issued, `done` at E0+17, pc does not wrap.
- Assert `load_valid` during RUN -> `load_ready`=0, memory unchanged on the next run. Reset at E0+1 -> outputs NOP(0) next edge, no `done`, `result`=0.
